// File: rtl/chacha_block_core_if.sv
// Load/next-block request and keystream output bundle of the ChaCha block core.
// master = key/nonce source and keystream consumer, slave = the core.
interface chacha_block_core_if;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  counter;
   logic         next_valid;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] keystream;
   logic         ctr_wrap;
   logic         busy;

   modport master (
      output in_valid, key, nonce, counter, next_valid, out_ready,
      input  in_ready, out_valid, keystream, ctr_wrap, busy
   );

   modport slave (
      input  in_valid, key, nonce, counter, next_valid, out_ready,
      output in_ready, out_valid, keystream, ctr_wrap, busy
   );
endinterface

// File: rtl/chacha_block_core.sv
// Sequential ChaCha8/12/20 block function with 1 or 4 quarter-round units,
// feed-forward add and a held keystream block behind a valid/ready handshake.
//
// state    | meaning
// S_IDLE   | waiting for a fresh load (in_valid) or a next-block request
// S_LOAD   | build initial state into working and saved registers
// S_ROUND  | one half-round (4 QR units) or one quarter-round (1 unit) per cycle
// S_FINAL  | keystream = working + saved
// S_DONE   | keystream presented until out_ready
module chacha_block_core #(
   parameter int ROUNDS       = 20,
   parameter int QR_PER_CYCLE = 4,
   parameter bit AUTO_INC     = 1'b1
) (
   input logic                clk,
   input logic                rst,
   chacha_block_core_if.slave bus
);

   if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
      $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
   end
   if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 4)) begin : g_bad_qr
      $error("chacha_block_core: QR_PER_CYCLE must be 1 or 4");
   end

   localparam int STEPS = (QR_PER_CYCLE == 4) ? ROUNDS : 4 * ROUNDS;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] key_q   [8];
   logic [31:0] key_d   [8];
   logic [31:0] nonce_q [3];
   logic [31:0] nonce_d [3];
   logic [31:0] ctr_q, ctr_d;
   logic [6:0]  step_q, step_d;
   logic [31:0] work_q  [16];
   logic [31:0] work_d  [16];
   logic [31:0] saved_q [16];
   logic [31:0] saved_d [16];
   logic [31:0] ks_q    [16];
   logic [31:0] ks_d    [16];
   logic        wrap_q, wrap_d;
   logic [31:0] init_w  [16];
   logic [31:0] round_w [16];

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] quarter(input logic [31:0] a_i, b_i, c_i, d_i);
      logic [31:0] a, b, c, d;
      a = a_i + b_i;  d = rotl(d_i ^ a, 16);
      c = c_i + d;    b = rotl(b_i ^ c, 12);
      a = a + b;      d = rotl(d ^ a, 8);
      c = c + d;      b = rotl(b ^ c, 7);
      return {d, c, b, a};
   endfunction

   always_comb begin
      init_w[0] = 32'h61707865;
      init_w[1] = 32'h3320646e;
      init_w[2] = 32'h79622d32;
      init_w[3] = 32'h6b206574;
      for (int k = 0; k < 8; k++) init_w[4 + k] = key_q[k];
      init_w[12] = ctr_q;
      for (int n = 0; n < 3; n++) init_w[13 + n] = nonce_q[n];
   end

   // Diagonal lane j touches rows shifted by 0..3 columns; columns use no shift.
   always_comb begin
      logic [1:0]   lane, off1, off2, off3;
      logic         diag;
      logic [3:0]   ia, ib, ic, id;
      logic [127:0] qr_out;
      round_w = work_q;
      lane = '0; off1 = '0; off2 = '0; off3 = '0; diag = 1'b0;
      ia = '0; ib = '0; ic = '0; id = '0; qr_out = '0;
      for (int l = 0; l < QR_PER_CYCLE; l++) begin
         lane   = (QR_PER_CYCLE == 4) ? 2'(l) : step_q[1:0];
         diag   = (QR_PER_CYCLE == 4) ? step_q[0] : step_q[2];
         off1   = {1'b0, diag};
         off2   = {diag, 1'b0};
         off3   = {diag, diag};
         ia     = {2'd0, lane};
         ib     = {2'd1, lane + off1};
         ic     = {2'd2, lane + off2};
         id     = {2'd3, lane + off3};
         qr_out = quarter(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
         round_w[ia] = qr_out[31:0];
         round_w[ib] = qr_out[63:32];
         round_w[ic] = qr_out[95:64];
         round_w[id] = qr_out[127:96];
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      nonce_d = nonce_q;
      ctr_d   = ctr_q;
      step_d  = step_q;
      work_d  = work_q;
      saved_d = saved_q;
      ks_d    = ks_q;
      wrap_d  = wrap_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               for (int k = 0; k < 8; k++) key_d[k] = bus.key[32*k +: 32];
               for (int n = 0; n < 3; n++) nonce_d[n] = bus.nonce[32*n +: 32];
               ctr_d   = bus.counter;
               wrap_d  = 1'b0;
               state_d = S_LOAD;
            end else if (bus.next_valid) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            work_d  = init_w;
            saved_d = init_w;
            step_d  = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            work_d = round_w;
            step_d = step_q + 7'd1;
            if (step_q == 7'(STEPS - 1)) state_d = S_FINAL;
         end
         S_FINAL: begin
            for (int i = 0; i < 16; i++) ks_d[i] = work_q[i] + saved_q[i];
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
               if (AUTO_INC) begin
                  ctr_d = ctr_q + 32'd1;
                  if (ctr_q == 32'hFFFF_FFFF) wrap_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         key_q   <= '{default: '0};
         nonce_q <= '{default: '0};
         ctr_q   <= '0;
         step_q  <= '0;
         work_q  <= '{default: '0};
         saved_q <= '{default: '0};
         ks_q    <= '{default: '0};
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         nonce_q <= nonce_d;
         ctr_q   <= ctr_d;
         step_q  <= step_d;
         work_q  <= work_d;
         saved_q <= saved_d;
         ks_q    <= ks_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);
   assign bus.ctr_wrap  = wrap_q;

   for (genvar i = 0; i < 16; i++) begin : g_ks
      assign bus.keystream[32*i +: 32] = ks_q[i];
   end

endmodule
